// File: rtl/ad9910_pkg.sv
// Slot map, frame helpers and FSM state encoding shared by the AD9910 SPI scheduler.
package ad9910_pkg;

    localparam int unsigned NUM_SLOTS = 8;
    localparam int unsigned SLOT_W    = 3;
    localparam int unsigned LEN_W     = 7;
    localparam int unsigned FRAME_W   = 72;

    localparam logic [SLOT_W-1:0] SLOT_CFR1     = 3'd0;
    localparam logic [SLOT_W-1:0] SLOT_CFR2     = 3'd1;
    localparam logic [SLOT_W-1:0] SLOT_CFR3     = 3'd2;
    localparam logic [SLOT_W-1:0] SLOT_ASF      = 3'd3;
    localparam logic [SLOT_W-1:0] SLOT_DRR      = 3'd4;
    localparam logic [SLOT_W-1:0] SLOT_DRL      = 3'd5;
    localparam logic [SLOT_W-1:0] SLOT_DRS      = 3'd6;
    localparam logic [SLOT_W-1:0] SLOT_PROFILE0 = 3'd7;

    localparam logic [7:0] ADDR_CFR1     = 8'h00;
    localparam logic [7:0] ADDR_CFR2     = 8'h01;
    localparam logic [7:0] ADDR_CFR3     = 8'h02;
    localparam logic [7:0] ADDR_ASF      = 8'h09;
    localparam logic [7:0] ADDR_DRR      = 8'h0D;
    localparam logic [7:0] ADDR_DRL      = 8'h0B;
    localparam logic [7:0] ADDR_DRS      = 8'h0C;
    localparam logic [7:0] ADDR_PROFILE0 = 8'h0E;

    typedef struct packed {
        logic              valid;
        logic [SLOT_W-1:0] idx;
    } slot_sel_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP,
        ST_IOUP
    } state_t;

    function automatic slot_sel_t slot_of(input logic [7:0] addr);
        slot_sel_t sel;
        sel = '{valid: 1'b1, idx: SLOT_CFR1};
        case (addr)
            ADDR_CFR1:     sel.idx = SLOT_CFR1;
            ADDR_CFR2:     sel.idx = SLOT_CFR2;
            ADDR_CFR3:     sel.idx = SLOT_CFR3;
            ADDR_ASF:      sel.idx = SLOT_ASF;
            ADDR_DRR:      sel.idx = SLOT_DRR;
            ADDR_DRL:      sel.idx = SLOT_DRL;
            ADDR_DRS:      sel.idx = SLOT_DRS;
            ADDR_PROFILE0: sel.idx = SLOT_PROFILE0;
            default:       sel.valid = 1'b0;
        endcase
        return sel;
    endfunction

    function automatic logic [7:0] slot_addr(input logic [SLOT_W-1:0] idx);
        logic [7:0] a;
        case (idx)
            SLOT_CFR1: a = ADDR_CFR1;
            SLOT_CFR2: a = ADDR_CFR2;
            SLOT_CFR3: a = ADDR_CFR3;
            SLOT_ASF:  a = ADDR_ASF;
            SLOT_DRR:  a = ADDR_DRR;
            SLOT_DRL:  a = ADDR_DRL;
            SLOT_DRS:  a = ADDR_DRS;
            default:   a = ADDR_PROFILE0;
        endcase
        return a;
    endfunction

    // Slots at or above DRL hold 64-bit registers.
    function automatic logic [LEN_W-1:0] frame_len(input logic [SLOT_W-1:0] idx);
        return (idx >= SLOT_DRL) ? LEN_W'(72) : LEN_W'(40);
    endfunction

endpackage

// File: rtl/ad9910_spi_shift.sv
// Variable-length SPI mode-0 shifter; frames are left-aligned in a 72-bit word.
module ad9910_spi_shift
    import ad9910_pkg::*;
#(
    parameter int unsigned HALF = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    input  logic [FRAME_W-1:0] frame,
    output logic               done_c,
    output logic               sck_o,
    output logic               mosi_o,
    output logic               cs_o
);

    localparam int unsigned DIV_W = 16;

    logic               active_q, active_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [LEN_W-1:0]   bits_q, bits_d;
    logic [FRAME_W-1:0] sr_q, sr_d;
    logic               sck_q, sck_d;
    logic               mosi_q, mosi_d;
    logic               cs_q, cs_d;
    logic               tick_c;

    always_comb begin
        active_d = active_q;
        div_d    = div_q;
        bits_d   = bits_q;
        sr_d     = sr_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        cs_d     = cs_q;
        done_c   = 1'b0;
        tick_c   = active_q && (div_q == DIV_W'(HALF - 1));
        if (start) begin
            active_d = 1'b1;
            div_d    = '0;
            bits_d   = len - LEN_W'(1);
            sr_d     = {frame[FRAME_W-2:0], 1'b0};
            mosi_d   = frame[FRAME_W-1];
            sck_d    = 1'b0;
            cs_d     = 1'b0;
        end else if (active_q) begin
            div_d = tick_c ? '0 : div_q + DIV_W'(1);
            if (tick_c) begin
                if (!sck_q) begin
                    sck_d = 1'b1;
                end else begin
                    // Falling edge: advance to the next bit or close the frame.
                    sck_d = 1'b0;
                    if (bits_q == '0) begin
                        cs_d     = 1'b1;
                        mosi_d   = 1'b0;
                        active_d = 1'b0;
                        done_c   = 1'b1;
                    end else begin
                        mosi_d = sr_q[FRAME_W-1];
                        sr_d   = {sr_q[FRAME_W-2:0], 1'b0};
                        bits_d = bits_q - LEN_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            div_q    <= '0;
            bits_q   <= '0;
            sr_q     <= '0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            cs_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            div_q    <= div_d;
            bits_q   <= bits_d;
            sr_q     <= sr_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
            cs_q     <= cs_d;
        end
    end

    assign sck_o  = sck_q;
    assign mosi_o = mosi_q;
    assign cs_o   = cs_q;

endmodule

// File: rtl/ad9910_spi_sched.sv
// AD9910 register-write scheduler: shadow slots, priority serialisation onto one
// SPI link, and a single IO_UPDATE pulse per batch of frames.
module ad9910_spi_sched
    import ad9910_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 50,
    parameter int unsigned SPI_CLK     = 10000,
    parameter int unsigned IOUP_CYCLES = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_addr,
    input  logic [63:0] wr_data,
    output logic        wr_err,
    output logic        busy,
    output logic        SCK_O,
    output logic        MOSI_O,
    output logic        CS_O,
    output logic        IO_UPDATE_O
);

    localparam int unsigned HALF_RAW = (CLK_FREQ * 1000) / (2 * SPI_CLK);
    localparam int unsigned HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int unsigned GAP_N    = 2 * HALF;
    localparam int unsigned IOUP_N   = (IOUP_CYCLES < 1) ? 1 : IOUP_CYCLES;
    localparam int unsigned CNT_W    = 16;

    state_t                 state_q, state_d;
    logic [NUM_SLOTS-1:0]   pending_q, pending_d;
    logic [63:0]            shadow_q [NUM_SLOTS];
    logic [63:0]            shadow_d [NUM_SLOTS];
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   wr_err_q, wr_err_d;
    logic                   busy_q, busy_d;
    logic                   ioup_q, ioup_d;

    slot_sel_t              sel_c;
    logic                   wr_ok_c;
    logic [SLOT_W-1:0]      win_idx_c;
    logic [LEN_W-1:0]       win_len_c;
    logic [63:0]            win_data_c;
    logic [FRAME_W-1:0]     frame_c;
    logic                   load_c;
    logic                   done_c;

    // Lowest-index pending slot wins.
    always_comb begin
        win_idx_c = '0;
        for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
            if (pending_q[i]) win_idx_c = SLOT_W'(i);
        end
    end

    assign win_len_c  = frame_len(win_idx_c);
    assign win_data_c = shadow_q[win_idx_c];
    assign frame_c    = (win_len_c == LEN_W'(72))
                      ? {slot_addr(win_idx_c), win_data_c}
                      : {slot_addr(win_idx_c), win_data_c[31:0], 32'h0};
    assign load_c     = (state_q == ST_LOAD);

    always_comb begin
        sel_c     = slot_of(wr_addr);
        wr_ok_c   = wr_en && sel_c.valid;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        // Clear before set so a write during LOAD keeps its slot pending.
        if (load_c) pending_d[win_idx_c] = 1'b0;
        if (wr_ok_c) begin
            pending_d[sel_c.idx] = 1'b1;
            shadow_d[sel_c.idx]  = wr_data;
        end
        case (state_q)
            ST_IDLE:  if (pending_d != '0) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (done_c) begin
                    state_d = ST_GAP;
                    cnt_d   = CNT_W'(GAP_N - 1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    if (pending_d != '0) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IOUP;
                        cnt_d   = CNT_W'(IOUP_N - 1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_IOUP: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default:  state_d = ST_IDLE;
        endcase
        wr_err_d = wr_en && !sel_c.valid;
        busy_d   = (state_d != ST_IDLE) || (pending_d != '0);
        ioup_d   = (state_d == ST_IOUP);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            shadow_q  <= '{default: '0};
            cnt_q     <= '0;
            wr_err_q  <= 1'b0;
            busy_q    <= 1'b0;
            ioup_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            cnt_q     <= cnt_d;
            wr_err_q  <= wr_err_d;
            busy_q    <= busy_d;
            ioup_q    <= ioup_d;
        end
    end

    ad9910_spi_shift #(.HALF(HALF)) u_shift (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .start  (load_c),
        .len    (win_len_c),
        .frame  (frame_c),
        .done_c (done_c),
        .sck_o  (SCK_O),
        .mosi_o (MOSI_O),
        .cs_o   (CS_O)
    );

    assign wr_err      = wr_err_q;
    assign busy        = busy_q;
    assign IO_UPDATE_O = ioup_q;

endmodule
